// File: rtl/regfile_if.sv
// Register-file bus: read ports, ALU write-back, flags load and clear/ready handshake.
// master = ALU/sequencer side, slave = register file.
interface regfile_if #(
    parameter int unsigned WIDTH = 16
);
    logic             clear;
    logic             ready;
    logic [3:0]       rd_addr1;
    logic [3:0]       rd_addr2;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             wr_en;
    logic [3:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             flags_en;
    logic [3:0]       flags_in;
    logic [3:0]       flags;

    modport master (
        output clear, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, flags_en, flags_in,
        input  ready, src1, src2, flags
    );

    modport slave (
        input  clear, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, flags_en, flags_in,
        output ready, src1, src2, flags
    );
endinterface

// File: rtl/regfile.sv
// 16 x WIDTH register file with hard-wired R0, INIT zeroing sweep, optional
// write-to-read forwarding and a separately loaded 4-bit flags register.
module regfile #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FWD   = 1
) (
    input  logic       clk,
    input  logic       rst,
    regfile_if.slave   bus
);
    localparam int unsigned NREG = 16;
    localparam int unsigned AW   = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [3:0]       flags_q, flags_d;
    logic             ready_q, ready_d;

    logic [WIDTH-1:0] mem [NREG];
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_wd;
    logic             fwd_ok;

    // State, sweep counter, flags and ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            flags_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            ready_q <= ready_d;
        end
    end

    // Next state, storage write port and flags load
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flags_d = flags_q;
        mem_we  = 1'b0;
        mem_wa  = bus.wr_addr;
        mem_wd  = bus.wr_data;
        case (state_q)
            INIT: begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = '0;
                if (bus.clear) begin
                    cnt_d = '0;
                end else if (cnt_q == AW'(NREG - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            RUN: begin
                if (bus.clear) begin
                    state_d = INIT;
                    cnt_d   = '0;
                    flags_d = '0;
                end else begin
                    mem_we = bus.wr_en && (bus.wr_addr != '0);
                    if (bus.flags_en) flags_d = bus.flags_in;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
        ready_d = (state_d == RUN);
    end

    // Storage carries no reset; the INIT sweep defines its contents
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // A write that clear is about to discard is not forwarded either
    assign fwd_ok = (FWD == 1) && (state_q == RUN) && bus.wr_en && !bus.clear
                    && (bus.wr_addr != '0);

    // Combinational read ports
    always_comb begin
        bus.src1 = '0;
        bus.src2 = '0;
        if (state_q == RUN) begin
            if (fwd_ok && (bus.rd_addr1 == bus.wr_addr)) bus.src1 = bus.wr_data;
            else if (bus.rd_addr1 != '0)                 bus.src1 = mem[bus.rd_addr1];
            if (fwd_ok && (bus.rd_addr2 == bus.wr_addr)) bus.src2 = bus.wr_data;
            else if (bus.rd_addr2 != '0)                 bus.src2 = mem[bus.rd_addr2];
        end
    end

    assign bus.ready = ready_q;
    assign bus.flags = flags_q;
endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: one forwarding and one non-forwarding
// instance share stimulus; expectations queue up and are checked each cycle.
module tb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [3:0]  rd_addr1, rd_addr2, wr_addr;
    logic        wr_en, flags_en;
    logic [15:0] wr_data;
    logic [3:0]  flags_in;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } exp_t;
    exp_t sb[$];

    localparam int SEL_READY  = 0;
    localparam int SEL_SRC1   = 1;
    localparam int SEL_SRC2   = 2;
    localparam int SEL_FLAGS  = 3;
    localparam int SEL_SRC1_0 = 4;
    localparam int SEL_SRC2_0 = 5;
    localparam int SEL_READY0 = 6;

    regfile_if #(.WIDTH(16)) bus1 ();
    regfile_if #(.WIDTH(16)) bus0 ();

    assign bus1.clear = clear;    assign bus0.clear = clear;
    assign bus1.rd_addr1 = rd_addr1; assign bus0.rd_addr1 = rd_addr1;
    assign bus1.rd_addr2 = rd_addr2; assign bus0.rd_addr2 = rd_addr2;
    assign bus1.wr_en = wr_en;    assign bus0.wr_en = wr_en;
    assign bus1.wr_addr = wr_addr; assign bus0.wr_addr = wr_addr;
    assign bus1.wr_data = wr_data; assign bus0.wr_data = wr_data;
    assign bus1.flags_en = flags_en; assign bus0.flags_en = flags_en;
    assign bus1.flags_in = flags_in; assign bus0.flags_in = flags_in;

    regfile #(.WIDTH(16), .FWD(1)) dut  (.clk(clk), .rst(rst), .bus(bus1));
    regfile #(.WIDTH(16), .FWD(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            SEL_READY:  return {15'd0, bus1.ready};
            SEL_SRC1:   return bus1.src1;
            SEL_SRC2:   return bus1.src2;
            SEL_FLAGS:  return {12'd0, bus1.flags};
            SEL_SRC1_0: return bus0.src1;
            SEL_SRC2_0: return bus0.src2;
            SEL_READY0: return {15'd0, bus0.ready};
            default:    return 16'hxxxx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Let combinational outputs settle, then drain the scoreboard
    task automatic check_all();
        exp_t e;
        #3;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear = 1'b0; wr_en = 1'b0; flags_en = 1'b0;
        wr_addr = '0; wr_data = '0; flags_in = '0;
    endtask

    // 16-edge INIT sweep: ready low until edge 16, writes/flags ignored, src zero
    task automatic run_sweep(input string name);
        for (int e = 1; e <= 16; e++) begin
            tick();
            rd_addr1 = 4'(e - 1);
            rd_addr2 = 4'(16 - e);
            if (e < 16) begin
                wr_en = 1'b1; wr_addr = 4'(e - 1); wr_data = 16'hffff;
                flags_en = 1'b1; flags_in = 4'hf;
            end else begin
                idle();
            end
            expect_val({name, "_ready"}, SEL_READY, (e == 16) ? 16'd1 : 16'd0);
            expect_val({name, "_ready0"}, SEL_READY0, (e == 16) ? 16'd1 : 16'd0);
            expect_val({name, "_src1"}, SEL_SRC1, 16'd0);
            expect_val({name, "_src2"}, SEL_SRC2, 16'd0);
            expect_val({name, "_flags"}, SEL_FLAGS, 16'd0);
            check_all();
        end
        for (int a = 0; a < 16; a++) begin
            rd_addr1 = 4'(a);
            rd_addr2 = 4'(15 - a);
            expect_val({name, "_zero1"}, SEL_SRC1, 16'd0);
            expect_val({name, "_zero2"}, SEL_SRC2, 16'd0);
            #1;
            check_all();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd_addr1 = '0; rd_addr2 = '0;
        #2;
        expect_val("por_ready", SEL_READY, 16'd0);
        expect_val("por_flags", SEL_FLAGS, 16'd0);
        check_all();

        // Reset release and INIT sweep
        tick();
        rst = 1'b0;
        run_sweep("rst");

        // Write R3/R4 then read both
        tick();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'd10;
        tick();
        wr_addr = 4'd4; wr_data = 16'd5;
        tick();
        idle();
        rd_addr1 = 4'd3; rd_addr2 = 4'd4;
        expect_val("rd_r3", SEL_SRC1, 16'd10);
        expect_val("rd_r4", SEL_SRC2, 16'd5);
        expect_val("rd_r3_nofwd", SEL_SRC1_0, 16'd10);
        check_all();

        // R0 write discarded, never forwarded
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hffff;
        rd_addr1 = 4'd0; rd_addr2 = 4'd0;
        expect_val("r0_fwd", SEL_SRC1, 16'd0);
        expect_val("r0_fwd2", SEL_SRC2, 16'd0);
        check_all();
        tick();
        idle();
        expect_val("r0_read", SEL_SRC1, 16'd0);
        expect_val("r0_read_nofwd", SEL_SRC1_0, 16'd0);
        check_all();

        // Forwarding on both ports at once
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'd15;
        rd_addr1 = 4'd5; rd_addr2 = 4'd5;
        expect_val("fwd_src1", SEL_SRC1, 16'd15);
        expect_val("fwd_src2", SEL_SRC2, 16'd15);
        expect_val("nofwd_src1_old", SEL_SRC1_0, 16'd0);
        expect_val("nofwd_src2_old", SEL_SRC2_0, 16'd0);
        check_all();
        tick();
        idle();
        expect_val("fwd_src1_next", SEL_SRC1, 16'd15);
        expect_val("nofwd_src1_new", SEL_SRC1_0, 16'd15);
        expect_val("nofwd_src2_new", SEL_SRC2_0, 16'd15);
        check_all();

        // Flags load, hold, and load alongside an R0 write
        flags_en = 1'b1; flags_in = 4'b0100;
        expect_val("flags_not_fwd", SEL_FLAGS, 16'd0);
        check_all();
        tick();
        flags_en = 1'b0; flags_in = 4'b1111;
        expect_val("flags_load", SEL_FLAGS, 16'h4);
        check_all();
        tick();
        expect_val("flags_hold", SEL_FLAGS, 16'h4);
        check_all();
        flags_en = 1'b1; flags_in = 4'b1010; wr_en = 1'b1; wr_addr = 4'd0;
        tick();
        idle();
        expect_val("flags_wr0", SEL_FLAGS, 16'ha);
        check_all();

        // Clear together with a write to R7 and a flags load
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1234;
        tick();
        idle();
        rd_addr1 = 4'd7;
        expect_val("r7_set", SEL_SRC1, 16'h1234);
        check_all();
        clear = 1'b1; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hbeef;
        flags_en = 1'b1; flags_in = 4'hf;
        tick();
        idle();
        expect_val("clr_ready", SEL_READY, 16'd0);
        expect_val("clr_flags", SEL_FLAGS, 16'd0);
        check_all();
        run_sweep("clr");
        rd_addr1 = 4'd7;
        expect_val("clr_r7", SEL_SRC1, 16'd0);
        expect_val("clr_flags_after", SEL_FLAGS, 16'd0);
        check_all();

        // Async reset mid-RUN, between edges
        flags_en = 1'b1; flags_in = 4'b0110;
        tick();
        idle();
        expect_val("pre_rst_flags", SEL_FLAGS, 16'h6);
        expect_val("pre_rst_ready", SEL_READY, 16'd1);
        check_all();
        rst = 1'b1;
        #1;
        expect_val("arst_ready", SEL_READY, 16'd0);
        expect_val("arst_flags", SEL_FLAGS, 16'd0);
        expect_val("arst_ready0", SEL_READY0, 16'd0);
        check_all();
        tick();
        tick();
        rst = 1'b0;

        // Clear mid-INIT restarts the sweep
        for (int i = 0; i < 5; i++) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect_val("init_clr_ready", SEL_READY, 16'd0);
        check_all();
        run_sweep("iclr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, setting the data width of registers, src1, src2 and wr_data.
REQ-002 The block SHALL have parameter FWD, default 1, which enables write-to-read forwarding when set to 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port clear, input, 1 bit: synchronous request to re-initialise all registers.
REQ-006 The block SHALL have port ready, output, 1 bit: high when in RUN; low during INIT.
REQ-007 The block SHALL have port rd_addr1, input, 4 bits: register index for src1.
REQ-008 The block SHALL have port rd_addr2, input, 4 bits: register index for src2.
REQ-009 The block SHALL have port src1, output, WIDTH bits: operand 1 to the ALU.
REQ-010 The block SHALL have port src2, output, WIDTH bits: operand 2 to the ALU.
REQ-011 The block SHALL have port wr_en, input, 1 bit: write strobe for the ALU result.
REQ-012 The block SHALL have port wr_addr, input, 4 bits: destination register index.
REQ-013 The block SHALL have port wr_data, input, WIDTH bits: ALU dst value.
REQ-014 The block SHALL have port flags_en, input, 1 bit: load strobe for the flags register.
REQ-015 The block SHALL have port flags_in, input, 4 bits: ALU flags value.
REQ-016 The block SHALL have port flags, output, 4 bits: registered flags.

Function
REQ-017 The storage SHALL hold 16 registers R0..R15 of WIDTH bits.
REQ-018 R0 SHALL always read 0, and writes to R0 SHALL be discarded.
REQ-019 The state machine SHALL have two states: INIT and RUN.
REQ-020 In INIT, a 4-bit counter SHALL write 0 to register[counter] each cycle, from 0 to 15, then the block SHALL enter RUN on the cycle after counter=15; INIT lasts 16 cycles.
REQ-021 In INIT, ready SHALL be 0, wr_en and flags_en SHALL be ignored, and src1/src2 SHALL be 0.
REQ-022 In RUN, clear=1 SHALL move the block to INIT on the next edge, with counter=0 and flags=0 on that edge; any wr_en or flags_en in that same cycle SHALL be discarded.
REQ-023 In INIT, clear SHALL restart the counter at 0.
REQ-024 Reads SHALL be combinational, with zero latency from rd_addr to src.
REQ-025 In RUN, wr_en=1 with wr_addr≠0 SHALL write wr_data to register[wr_addr] on the edge.
REQ-026 When FWD=1, in RUN with wr_en=1, wr_addr≠0 and wr_addr=rd_addrN, srcN SHALL equal wr_data in the same cycle.
REQ-027 When FWD=0, srcN SHALL show the stored value, and the new value SHALL be visible from the next cycle.
REQ-028 Both read ports SHALL apply forwarding independently, including when rd_addr1=rd_addr2=wr_addr.
REQ-029 In RUN, flags_en=1 SHALL load flags_in into flags on the edge, independent of wr_en and wr_addr, including wr_addr=0.
REQ-030 Flags SHALL NOT be forwarded and SHALL update one cycle after flags_en.

Reset
REQ-031 rst=1 SHALL immediately, without waiting for clk, set state=INIT, counter=0, flags=0 and ready=0.
REQ-032 Register contents after rst SHALL be undefined until the INIT sweep completes; src outputs SHALL be 0 while in INIT.
REQ-033 When rst is released, the INIT sweep SHALL start at the first clk edge, and ready SHALL rise 16 edges later.
REQ-034 rst asserted mid-INIT or mid-RUN SHALL abort the current activity and restart per REQ-031.

Verification
REQ-035 The bench SHALL cover reset: assert rst, release it, and count edges -> ready=0 for exactly 16 edges, then 1; src1=src2=0 for all addresses; flags=0000.
REQ-036 The bench SHALL cover write/read: write R3=10 and R4=5, then read rd_addr1=3 and rd_addr2=4 -> src1=10 and src2=5; writing R0=0xFFFF -> reading R0 gives 0.
REQ-037 The bench SHALL cover forwarding with FWD=1: wr_en=1, wr_addr=5, wr_data=15, rd_addr1=rd_addr2=5 in the same cycle -> src1=src2=15 in that cycle; with FWD=0 -> the old value (0) that cycle and 15 the next.
REQ-038 The bench SHALL cover flags: flags_en=1 with flags_in=0100 -> flags=0100 after one edge; with flags_en=0, flags_in=1111 -> flags stays 0100.
REQ-039 The bench SHALL cover clear: with R7=0x1234, pulse clear together with wr_en to R7 -> ready=0 for 16 cycles, R7 reads 0 afterwards and flags=0000; the write is discarded.
REQ-040 The bench SHALL cover asynchronous reset: assert rst between clock edges during RUN -> ready and flags drop to 0 before the next edge.
